// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, the default
// wait-state timeout and the load-byte extension helper.
package lsu_pkg;

    // Default number of cycles waited for any single mem_done edge.
    localparam int LSU_TIMEOUT_DEFAULT = 255;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_LO = 3'd1,
        REL_LO = 3'd2,
        REQ_HI = 3'd3,
        REL_HI = 3'd4
    } lsu_state_t;

    // Byte load result: sign-extend when sgn is set, otherwise zero-extend.
    function automatic logic [15:0] lsu_extend(input logic [7:0] b, input logic sgn);
        logic [7:0] hi_v;
        hi_v = (sgn && b[7]) ? 8'hFF : 8'h00;
        return {hi_v, b};
    endfunction

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit: turns one core command (byte or 16-bit, load or store)
// into one or two four-phase byte transactions on the data-memory port.
// Words are little-endian; the high byte lives at cmd_addr+1 (wrapping).
// Every wait state is bounded by TIMEOUT_CYCLES and aborts with rsp_err.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_word,
    input  logic        cmd_signed,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [15:0] rsp_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        mem_write,
    output logic        mem_req,
    input  logic        mem_done
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Value of the counter during the last permitted wait cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t       state_r;
    logic             write_r;
    logic             word_r;
    logic             signed_r;
    logic [15:0]      addr_r;
    logic [15:0]      wdata_r;
    logic [7:0]       rdata_lo_r;
    logic [CNT_W-1:0] cnt_r;
    logic             cnt_last_s;

    // A responder still holding done (e.g. after an abort) blocks new commands.
    assign cmd_ready  = (state_r == IDLE) && !mem_done;
    assign cnt_last_s = (cnt_r == CNT_LAST);

    // Command FSM, memory handshake, wait-state timeout and response outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            write_r    <= 1'b0;
            word_r     <= 1'b0;
            signed_r   <= 1'b0;
            addr_r     <= 16'h0000;
            wdata_r    <= 16'h0000;
            rdata_lo_r <= 8'h00;
            cnt_r      <= '0;
            mem_req    <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= 16'h0000;
            mem_wdata  <= 8'h00;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= 16'h0000;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (cmd_valid && cmd_ready) begin
                        write_r   <= cmd_write;
                        word_r    <= cmd_word;
                        signed_r  <= cmd_signed;
                        addr_r    <= cmd_addr;
                        wdata_r   <= cmd_wdata;
                        state_r   <= REQ_LO;
                        mem_req   <= 1'b1;
                        mem_addr  <= cmd_addr;
                        mem_write <= cmd_write;
                        mem_wdata <= cmd_write ? cmd_wdata[7:0] : 8'h00;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ_LO: begin
                    if (mem_done) begin
                        cnt_r     <= '0;
                        state_r   <= REL_LO;
                        mem_req   <= 1'b0;
                        mem_write <= 1'b0;
                        mem_wdata <= 8'h00;
                        if (word_r) begin
                            rdata_lo_r <= mem_rdata;
                        end else begin
                            rsp_valid <= 1'b1;
                            if (!write_r) begin
                                rsp_rdata <= lsu_extend(mem_rdata, signed_r);
                            end else begin
                                rsp_rdata <= rsp_rdata;
                            end
                        end
                    end else if (cnt_last_s) begin
                        cnt_r     <= '0;
                        state_r   <= IDLE;
                        mem_req   <= 1'b0;
                        mem_write <= 1'b0;
                        mem_wdata <= 8'h00;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                REL_LO: begin
                    if (!mem_done) begin
                        cnt_r <= '0;
                        if (word_r) begin
                            state_r   <= REQ_HI;
                            mem_req   <= 1'b1;
                            mem_addr  <= addr_r + 16'd1;
                            mem_write <= write_r;
                            mem_wdata <= write_r ? wdata_r[15:8] : 8'h00;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (cnt_last_s) begin
                        cnt_r     <= '0;
                        state_r   <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                REQ_HI: begin
                    if (mem_done) begin
                        cnt_r     <= '0;
                        state_r   <= REL_HI;
                        mem_req   <= 1'b0;
                        mem_write <= 1'b0;
                        mem_wdata <= 8'h00;
                        rsp_valid <= 1'b1;
                        if (!write_r) begin
                            rsp_rdata <= {mem_rdata, rdata_lo_r};
                        end else begin
                            rsp_rdata <= rsp_rdata;
                        end
                    end else if (cnt_last_s) begin
                        cnt_r     <= '0;
                        state_r   <= IDLE;
                        mem_req   <= 1'b0;
                        mem_write <= 1'b0;
                        mem_wdata <= 8'h00;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                REL_HI: begin
                    if (!mem_done) begin
                        cnt_r   <= '0;
                        state_r <= IDLE;
                    end else if (cnt_last_s) begin
                        cnt_r     <= '0;
                        state_r   <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_r     <= '0;
                    state_r   <= IDLE;
                    mem_req   <= 1'b0;
                    mem_write <= 1'b0;
                    mem_wdata <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a behavioural byte-memory responder
// checks each memory transaction against a queue of expected transactions,
// and a response monitor checks each rsp_valid pulse against a queue of
// expected responses.
module tb_load_store_unit;

    localparam int TMO = 8;

    typedef struct packed {
        logic [15:0] addr;
        logic        wr;
        logic [7:0]  wdata;
        logic        last;
    } txn_t;

    typedef struct packed {
        logic        err;
        logic [15:0] rdata;
    } rsp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic        cmd_word = 1'b0;
    logic        cmd_signed = 1'b0;
    logic [15:0] cmd_addr = 16'h0000;
    logic [15:0] cmd_wdata = 16'h0000;
    logic        rsp_valid;
    logic        rsp_err;
    logic [15:0] rsp_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_write;
    logic        mem_req;
    logic        mem_done = 1'b0;

    int checks = 0;
    int errors = 0;
    int idle_violations = 0;

    txn_t txn_q[$];
    rsp_t rsp_q[$];
    logic [7:0] mem_model [0:65535];
    logic [15:0] last_rdata = 16'h0000;

    // Responder controls: 0 = normal, 1 = never done, 2 = done stuck high.
    int   resp_mode = 0;
    int   resp_delay = 2;
    logic release_stuck = 1'b0;
    int   r_state = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_word(cmd_word), .cmd_signed(cmd_signed),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_write(mem_write), .mem_req(mem_req), .mem_done(mem_done)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte-memory responder, sampling away from the active edge.
    initial begin : responder
        txn_t cur;
        int   cnt;
        int   req_cycles;
        cur = '0;
        cnt = 0;
        req_cycles = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                r_state  = 0;
                mem_done = 1'b0;
            end else begin
                case (r_state)
                    0: if (mem_req) begin
                        if (txn_q.size() == 0) begin
                            check_eq("txn_unexpected", 32'(1), 32'(0));
                            cur = '0;
                        end else begin
                            cur = txn_q.pop_front();
                            check_eq("txn_addr", 32'(mem_addr), 32'(cur.addr));
                            check_eq("txn_write", 32'(mem_write), 32'(cur.wr));
                            if (cur.wr) check_eq("txn_wdata", 32'(mem_wdata), 32'(cur.wdata));
                        end
                        cnt = 0;
                        req_cycles = 1;
                        r_state = (resp_mode == 1) ? 3 : 1;
                    end
                    1: begin
                        cnt++;
                        if (cnt >= resp_delay) begin
                            mem_rdata = mem_model[mem_addr];
                            if (mem_write) mem_model[mem_addr] = mem_wdata;
                            mem_done = 1'b1;
                            r_state = 2;
                        end
                    end
                    2: if (!mem_req) begin
                        if (cur.last) check_eq("rsp_latency", 32'(rsp_valid), 32'(1));
                        r_state = (resp_mode == 2) ? 5 : 4;
                    end
                    3: begin
                        if (mem_req) begin
                            req_cycles++;
                        end else begin
                            check_eq("timeout_req_cycles", 32'(req_cycles), 32'(TMO));
                            r_state = 0;
                        end
                    end
                    4: begin
                        check_eq("req_low_until_done_low", 32'(mem_req), 32'(0));
                        mem_done = 1'b0;
                        r_state = 0;
                    end
                    5: if (release_stuck) begin
                        mem_done = 1'b0;
                        r_state = 0;
                    end
                    default: r_state = 0;
                endcase
            end
        end
    end

    // Response monitor and idle-port watcher.
    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge clock);
            if (!mem_req && (mem_write !== 1'b0 || mem_wdata !== 8'h00)) idle_violations++;
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check_eq("rsp_spurious", 32'(1), 32'(0));
                end else begin
                    e = rsp_q.pop_front();
                    check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
                    check_eq("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                end
            end
        end
    end

    task automatic send_cmd(input logic wr, input logic wd, input logic sg,
                            input logic [15:0] a, input logic [15:0] d);
        int n;
        n = 0;
        @(negedge clock);
        while (!cmd_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) check_eq("cmd_ready_wait", 32'(cmd_ready), 32'(1));
        cmd_write = wr; cmd_word = wd; cmd_signed = sg; cmd_addr = a; cmd_wdata = d;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!(txn_q.size() == 0 && rsp_q.size() == 0 && r_state == 0 && !mem_req) && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) check_eq(tag, 32'(0), 32'(1));
    endtask

    // Push expected transactions and response for a normally completing command.
    task automatic expect_cmd(input logic wr, input logic wd, input logic sg,
                              input logic [15:0] a, input logic [15:0] d);
        logic [15:0] a1;
        rsp_t r;
        a1 = a + 16'd1;
        txn_q.push_back('{addr: a, wr: wr, wdata: d[7:0], last: !wd});
        if (wd) txn_q.push_back('{addr: a1, wr: wr, wdata: d[15:8], last: 1'b1});
        if (wr) r.rdata = last_rdata;
        else if (wd) r.rdata = {mem_model[a1], mem_model[a]};
        else r.rdata = {((sg && mem_model[a][7]) ? 8'hFF : 8'h00), mem_model[a]};
        r.err = 1'b0;
        last_rdata = r.rdata;
        rsp_q.push_back(r);
    endtask

    task automatic run_cmd(input string tag, input logic wr, input logic wd, input logic sg,
                           input logic [15:0] a, input logic [15:0] d);
        expect_cmd(wr, wd, sg, a, d);
        send_cmd(wr, wd, sg, a, d);
        wait_done(tag);
    endtask

    initial begin : main
        int n;
        for (int i = 0; i < 65536; i++) mem_model[i] = 8'h00;
        mem_model[16'h0020] = 8'hEF;
        mem_model[16'h0021] = 8'hBE;
        mem_model[16'h0040] = 8'h80;
        mem_model[16'h0041] = 8'h7F;
        mem_model[16'h0060] = 8'h11;
        mem_model[16'h0030] = 8'h12;
        mem_model[16'h0031] = 8'h34;

        // Reset state.
        repeat (3) @(negedge clock);
        check_eq("reset_mem_req", 32'(mem_req), 32'(0));
        check_eq("reset_rsp_valid", 32'(rsp_valid), 32'(0));
        check_eq("reset_rsp_rdata", 32'(rsp_rdata), 32'(0));
        check_eq("reset_mem_addr", 32'(mem_addr), 32'(0));
        check_eq("reset_mem_wdata", 32'(mem_wdata), 32'(0));
        check_eq("reset_mem_write", 32'(mem_write), 32'(0));
        #2 reset = 1'b0;
        @(negedge clock);
        check_eq("reset_cmd_ready", 32'(cmd_ready), 32'(1));

        // Byte store, word load, signed/unsigned byte loads, wrapping word store.
        resp_delay = 2;
        run_cmd("byte_store", 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0034);
        check_eq("mem_0010", 32'(mem_model[16'h0010]), 32'(8'h34));
        run_cmd("word_load", 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
        run_cmd("byte_load_s", 1'b0, 1'b0, 1'b1, 16'h0040, 16'h0000);
        run_cmd("byte_load_u", 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000);
        resp_delay = 0;
        run_cmd("byte_load_s_pos", 1'b0, 1'b0, 1'b1, 16'h0041, 16'h0000);
        resp_delay = 3;
        run_cmd("word_store_wrap", 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'hA55A);
        check_eq("mem_ffff", 32'(mem_model[16'hFFFF]), 32'(8'h5A));
        check_eq("mem_0000", 32'(mem_model[16'h0000]), 32'(8'hA5));
        run_cmd("word_load_wrap", 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000);

        // Responder never answers: abort with error, rdata untouched.
        resp_mode = 1;
        txn_q.push_back('{addr: 16'h0050, wr: 1'b0, wdata: 8'h00, last: 1'b1});
        rsp_q.push_back('{err: 1'b1, rdata: last_rdata});
        send_cmd(1'b0, 1'b0, 1'b0, 16'h0050, 16'h0000);
        wait_done("timeout_req");
        check_eq("timeout_cmd_ready", 32'(cmd_ready), 32'(1));
        resp_mode = 0;

        // Responder holds done forever: release wait times out, ready blocked.
        resp_mode = 2;
        resp_delay = 1;
        txn_q.push_back('{addr: 16'h0060, wr: 1'b0, wdata: 8'h00, last: 1'b1});
        rsp_q.push_back('{err: 1'b0, rdata: 16'h0011});
        rsp_q.push_back('{err: 1'b1, rdata: 16'h0011});
        last_rdata = 16'h0011;
        send_cmd(1'b0, 1'b0, 1'b0, 16'h0060, 16'h0000);
        n = 0;
        while (rsp_q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) check_eq("stuck_rsp_wait", 32'(0), 32'(1));
        repeat (3) @(negedge clock);
        check_eq("stuck_cmd_ready_low", 32'(cmd_ready), 32'(0));
        release_stuck = 1'b1;
        @(negedge clock);
        #1 check_eq("stuck_cmd_ready_back", 32'(cmd_ready), 32'(1));
        release_stuck = 1'b0;
        resp_mode = 0;
        resp_delay = 2;

        // A command offered while busy must be ignored.
        resp_delay = 4;
        expect_cmd(1'b1, 1'b0, 1'b0, 16'h0070, 16'h0077);
        send_cmd(1'b1, 1'b0, 1'b0, 16'h0070, 16'h0077);
        n = 0;
        @(negedge clock);
        while (!cmd_ready && n < 100) begin
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_word = 1'b1; cmd_addr = 16'h0100;
            @(negedge clock);
            n++;
        end
        cmd_valid = 1'b0;
        wait_done("busy_ignore");
        repeat (4) @(negedge clock);
        check_eq("busy_no_extra_req", 32'(mem_req), 32'(0));
        check_eq("mem_0070", 32'(mem_model[16'h0070]), 32'(8'h77));

        // Reset during the high-byte request: immediate drop, no response.
        resp_delay = 3;
        txn_q.push_back('{addr: 16'h0030, wr: 1'b0, wdata: 8'h00, last: 1'b0});
        txn_q.push_back('{addr: 16'h0031, wr: 1'b0, wdata: 8'h00, last: 1'b1});
        send_cmd(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000);
        n = 0;
        while (!(mem_req && mem_addr == 16'h0031) && n < 100) begin
            @(negedge clock);
            n++;
        end
        check_eq("reach_req_hi", 32'(mem_req), 32'(1));
        #2 reset = 1'b1;
        #1 check_eq("async_reset_req", 32'(mem_req), 32'(0));
        check_eq("async_reset_rsp", 32'(rsp_valid), 32'(0));
        check_eq("async_reset_rdata", 32'(rsp_rdata), 32'(0));
        last_rdata = 16'h0000;
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        check_eq("post_reset_cmd_ready", 32'(cmd_ready), 32'(1));
        check_eq("post_reset_txn_q", 32'(txn_q.size()), 32'(0));
        run_cmd("post_reset_load", 1'b0, 1'b0, 1'b1, 16'h0040, 16'h0000);

        repeat (5) @(negedge clock);
        check_eq("idle_port_violations", 32'(idle_violations), 32'(0));
        check_eq("rsp_q_empty", 32'(rsp_q.size()), 32'(0));
        check_eq("txn_q_empty", 32'(txn_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
